// File: rtl/top_proc_pkg.sv
// top_proc_pkg: opcodes and frame geometry shared by the bit-serial accumulator processor
package top_proc_pkg;
    localparam int OPW = 3;
    localparam logic [OPW-1:0] OP_LOAD = 3'b000;
    localparam logic [OPW-1:0] OP_ADD  = 3'b001;
    localparam logic [OPW-1:0] OP_SUB  = 3'b010;
    localparam logic [OPW-1:0] OP_AND  = 3'b011;
    localparam logic [OPW-1:0] OP_OR   = 3'b100;
    localparam logic [OPW-1:0] OP_XOR  = 3'b101;
    localparam logic [OPW-1:0] OP_NOT  = 3'b110;
    localparam logic [OPW-1:0] OP_OUT  = 3'b111;

    function automatic int frame_len(input int n);
        return n + OPW;
    endfunction
endpackage

// File: rtl/top_proc_alu.sv
// top_proc_alu: next accumulator value for one decoded instruction
module top_proc_alu
    import top_proc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic [OPW-1:0] op_i,
    input  logic [N-1:0]   acc_i,
    input  logic [N-1:0]   operand_i,
    output logic [N-1:0]   acc_o
);
    always_comb begin
        acc_o = acc_i;
        case (op_i)
            OP_LOAD: acc_o = operand_i;
            OP_ADD:  acc_o = acc_i + operand_i;
            OP_SUB:  acc_o = acc_i - operand_i;
            OP_AND:  acc_o = acc_i & operand_i;
            OP_OR:   acc_o = acc_i | operand_i;
            OP_XOR:  acc_o = acc_i ^ operand_i;
            OP_NOT:  acc_o = ~acc_i;
            default: acc_o = acc_i;
        endcase
    end
endmodule

// File: rtl/top_proc.sv
// top_proc: bit-serial accumulator processor; deserialises frames, executes on the
// last frame bit and serialises the accumulator on OUT
module top_proc
    import top_proc_pkg::*;
#(
    parameter int N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic data,
    output logic write,
    output logic result
);
    localparam int FL  = frame_len(N);
    localparam int CW  = $clog2(FL);
    localparam int OCW = $clog2(N + 1);

    logic [CW-1:0]  cnt_q;
    logic [FL-2:0]  sr_q;
    logic [N-1:0]   acc_q, acc_d, out_q;
    logic [OCW-1:0] ocnt_q;
    logic           write_q;
    logic [FL-1:0]  frame;
    logic           last;

    // the live bit completes the frame, so execution has zero latency
    assign frame  = {sr_q, data};
    assign last   = cnt_q == CW'(FL - 1);
    assign write  = write_q;
    assign result = write_q & out_q[N-1];

    top_proc_alu #(.N(N)) u_alu (
        .op_i      (frame[FL-1 -: OPW]),
        .acc_i     (acc_q),
        .operand_i (frame[N-1:0]),
        .acc_o     (acc_d)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q   <= '0;
            sr_q    <= '0;
            acc_q   <= '0;
            out_q   <= '0;
            ocnt_q  <= '0;
            write_q <= 1'b0;
        end else begin
            cnt_q <= last ? '0 : cnt_q + 1'b1;
            sr_q  <= frame[FL-2:0];
            if (last)
                acc_q <= acc_d;
            if (last && frame[FL-1 -: OPW] == OP_OUT) begin
                out_q   <= acc_q;
                ocnt_q  <= OCW'(N);
                write_q <= 1'b1;
            end else if (ocnt_q != '0) begin
                out_q   <= out_q << 1;
                ocnt_q  <= ocnt_q - 1'b1;
                write_q <= ocnt_q != OCW'(1);
            end else begin
                write_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_top_proc.sv
// tb_top_proc: directed frames against a queue-based behavioural model of the processor
module tb_top_proc;
    localparam int N = 2;
    localparam int F = N + 3;
    localparam int M = (1 << N) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic data = 1'b1;
    logic write, result;

    int vec = 0;
    int errs = 0;
    bit chk_en = 1'b0;

    int m_acc = 0;
    bit fq[$];
    bit oq[$];
    bit cap_q[$];
    bit exp_w = 1'b0;
    bit exp_r = 1'b0;

    top_proc #(.N(N)) dut (
        .clk    (clk),
        .rst    (rst),
        .data   (data),
        .write  (write),
        .result (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        vec++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // model works on whole frames and a queue of pending output bits
    task automatic model(input bit r, input bit d);
        int op, v;
        if (r) begin
            fq.delete();
            oq.delete();
            m_acc = 0;
        end else begin
            if (oq.size() != 0)
                void'(oq.pop_front());
            fq.push_back(d);
            if (fq.size() == F) begin
                op = 4 * fq[0] + 2 * fq[1] + fq[2];
                v = 0;
                for (int i = 3; i < F; i++)
                    v = 2 * v + fq[i];
                case (op)
                    0: m_acc = v;
                    1: m_acc = (m_acc + v) & M;
                    2: m_acc = (m_acc - v + (1 << N)) & M;
                    3: m_acc = m_acc & v;
                    4: m_acc = m_acc | v;
                    5: m_acc = m_acc ^ v;
                    6: m_acc = ~m_acc & M;
                    default: for (int i = N - 1; i >= 0; i--) oq.push_back(bit'((m_acc >> i) & 1));
                endcase
                fq.delete();
            end
        end
        exp_w = oq.size() != 0;
        exp_r = exp_w ? oq[0] : 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("write", int'(write), int'(exp_w));
            chk("result", int'(result), int'(exp_r));
        end
    end

    task automatic apply(input bit r, input bit d);
        rst = r;
        data = d;
        @(posedge clk);
        model(r, d);
        @(negedge clk);
        if (write)
            cap_q.push_back(result);
    endtask

    task automatic send(input logic [2:0] op, input logic [N-1:0] v);
        logic [F-1:0] bits;
        bits = {op, v};
        for (int i = F - 1; i >= 0; i--)
            apply(1'b0, bits[i]);
    endtask

    task automatic lit(input string name, input logic [1:0] e);
        chk({name, "_len"}, cap_q.size(), 2);
        if (cap_q.size() == 2)
            chk({name, "_bits"}, int'({cap_q[0], cap_q[1]}), int'(e));
    endtask

    // OUT followed by the next frame, which spans the whole 2-bit output burst
    task automatic out_then(input string name, input logic [2:0] op, input logic [N-1:0] v, input logic [1:0] e);
        cap_q.delete();
        send(3'b111, 2'b00);
        send(op, v);
        lit(name, e);
    endtask

    initial begin
        chk_en = 1'b1;
        apply(1'b1, 1'b1);
        chk("rst_write", int'(write), 0);
        chk("rst_result", int'(result), 0);
        repeat (3) apply(1'b1, 1'b1);
        chk("rst_hold_write", int'(write), 0);

        send(3'b000, 2'b10);
        out_then("load_out", 3'b000, 2'b11, 2'b10);
        chk("load_out_idle", int'(write), 0);

        send(3'b001, 2'b10);
        out_then("add_wrap", 3'b000, 2'b01, 2'b01);
        send(3'b010, 2'b10);
        out_then("sub", 3'b000, 2'b10, 2'b11);

        send(3'b101, 2'b11);
        out_then("xor", 3'b100, 2'b10, 2'b01);
        out_then("or", 3'b110, 2'b00, 2'b11);
        out_then("not", 3'b011, 2'b11, 2'b00);
        out_then("and", 3'b000, 2'b00, 2'b00);

        apply(1'b1, 1'b1);
        cap_q.delete();
        repeat (16) apply(1'b0, 1'b1);
        chk("ones_len", cap_q.size(), 6);
        chk("ones_bits", cap_q.sum() with (int'(item)), 0);
        repeat (14) apply(1'b0, 1'b0);
        chk("ones_drain_len", cap_q.size(), 6);
        chk("ones_drain_write", int'(write), 0);

        apply(1'b0, 1'b1);
        apply(1'b0, 1'b1);
        apply(1'b1, 1'b0);
        send(3'b000, 2'b01);
        out_then("rst_mid", 3'b000, 2'b00, 2'b01);

        send(3'b000, 2'b11);
        send(3'b111, 2'b00);
        chk("abort_pre_write", int'(write), 1);
        apply(1'b1, 1'b0);
        chk("abort_write", int'(write), 0);
        out_then("abort_acc", 3'b000, 2'b00, 2'b00);

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule

// File: doc/top_proc.md
Name: top_proc

Overview:
- Bit-serial accumulator microprocessor.
- Instructions arrive one bit per clock on `data`, framed back-to-back with no start bit.
- Each frame is executed against an N-bit accumulator.
- An OUT instruction shifts the accumulator out serially on `result`, with `write` as the valid strobe.
- Leaf processing block; system top of the processor.

Parameters:
- N, 2, accumulator/operand width in bits (N >= 1).

Ports:
- clk     input   1  system clock, all logic on rising edge
- rst     input   1  synchronous, active-high reset
- data    input   1  serial instruction stream, MSB first, sampled every rising edge when rst=0
- write   output  1  high while `result` carries a valid accumulator bit
- result  output  1  serial accumulator output, MSB first

Behaviour:
- One clock; reset is synchronous and active-high (ports `clk`, `rst`).
- Reset values: acc=0, bit counter=0, input shift reg=0, output shift reg=0, output count=0, write=0, result=0.
- Frame format: F = N+3 bits.
  - Bits are opcode[2:0] then operand[N-1:0], each field MSB first.
  - Frames are contiguous; the first bit sampled on the first edge with rst=0 starts frame 0.
- Bit counter: runs 0..F-1 and increments every non-reset edge. At count F-1 the frame is complete; the counter wraps to 0.
- Execute: on the edge sampling the last frame bit, decode {shift reg, data}. acc updates on that same edge (latency 0 after the last bit).
- Opcodes:
  - 000 LOAD: acc = operand
  - 001 ADD: acc = (acc + operand) mod 2^N
  - 010 SUB: acc = (acc - operand) mod 2^N
  - 011 AND: acc = acc & operand
  - 100 OR: acc = acc | operand
  - 101 XOR: acc = acc ^ operand
  - 110 NOT: acc = ~acc; operand ignored
  - 111 OUT: acc unchanged; operand ignored; start output
- Output:
  - On the OUT execute edge, the output shift reg loads acc and the output count loads N.
  - Each later edge with count != 0: shift left by one and decrement the count.
  - write = (count != 0), registered.
  - result = output shift reg MSB when write=1, else 0.
  - `write` is high for exactly N cycles, starting the cycle after the last OUT bit.
- Overlap: output (N cycles) always completes before the next frame can execute (F = N+3 > N), so a new OUT never collides with an active one.
- Reception of the next frame continues during output shifting.
- Reset mid-frame: the partial frame is discarded and any output in progress is aborted (write=0 the next cycle). The frame boundary re-aligns to the first post-reset edge.
- Arithmetic is unsigned, N bits wide; the carry/borrow is discarded.

Decomposition:
- Package top_proc_pkg holds:
  - opcode localparams (OP_LOAD..OP_OUT)
  - opcode width constant OPW=3
  - frame-length function F(N)
- One sub-module is natural: top_proc_alu, combinational, taking (op, acc, operand) to next acc, parameterised by N.
- Deserializer, counter and serializer stay in the top.

Test Plan (N=2, F=5, frames listed as bit sequences):
- Reset: rst=1 for 1 edge with data=1 -> write=0, result=0, acc=0; hold reset 3 edges -> write stays 0.
- LOAD+OUT: 000 10, then 111 00 -> acc=2'b10; write=1 for 2 cycles after the OUT frame's last bit; result 1 then 0; write=0 afterwards.
- ADD wrap: LOAD 11, ADD 10, OUT -> result 0 then 1 (3+2=5 mod 4=1). SUB: LOAD 01, SUB 10, OUT -> 1,1.
- Logic ops: LOAD 10, XOR 11, OUT -> 0,1. Then OR 10, OUT -> 1,1. Then NOT, OUT -> 0,0. Then AND 11, OUT -> 0,0.
- All-ones stream after reset (data=1 continuously): every frame is OUT of acc=0. write pattern per frame is low for 5 cycles after reset, then 1,1,0,0,0 repeating; result stays 0. Switching data to 0 mid-frame yields LOAD frames and stops write after the current output drains.
- Reset mid-operation: 2 bits of a frame then rst for 1 edge -> the next 5 bits form a complete frame (LOAD 01 then OUT gives 0,1). rst during active write -> write=0 next cycle, acc=0.
